// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle CPU control unit. Owns the IF/ID/EXE/MEM/WB state register,
// latches the opcode during fetch and drives every datapath control signal
// from the current state, the latched opcode and the ALU zero flag. It also
// handles the imem/dmem ready handshakes, a sticky halt flag, illegal-opcode
// detection and a retired-instruction counter.
//
// Ports
//   CLK          rising-edge clock
//   Reset        asynchronous, active-low reset
//   Opcode       opcode from instruction memory, sampled in IF
//   Zero         ALU zero flag
//   imem_ready   instruction memory data valid
//   dmem_ready   data memory access complete
//   state        current state encoding
//   IRWre        instruction register write enable
//   PCWre        PC write enable (final cycle of each instruction)
//   RegWre       register file write enable
//   ALUSrcB      ALU B operand select (immediate)
//   ALUM2Reg     write-back data from memory
//   DataMemRW    data memory write
//   WrRegData    register write data select
//   ALUOp        ALU operation
//   ExtSel       immediate extension select
//   PCSrc        next-PC select
//   RegOut       destination register select
//   halted       sticky halt flag
//   illegal      one-cycle pulse on an unknown opcode
//   retired      count of completed instructions (wraps)
// -----------------------------------------------------------------------------
module mc_control_unit #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [OP_W-1:0]  Opcode,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             IRWre,
    output logic             PCWre,
    output logic             RegWre,
    output logic             ALUSrcB,
    output logic             ALUM2Reg,
    output logic             DataMemRW,
    output logic             WrRegData,
    output logic [2:0]       ALUOp,
    output logic [1:0]       ExtSel,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegOut,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_MOVE = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_SLT  = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110100);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE3 = 3'b101,
        S_EXE4 = 3'b110,
        S_EXE5 = 3'b010,
        S_MEM  = 3'b011,
        S_WB4  = 3'b111,
        S_WB5  = 3'b100
    } state_t;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q;
    logic            is_alu, is_jump, is_rtype;
    logic            irwre_c, regwre_c, dmemrw_c, alum2reg_c, wrregdata_c;
    logic            retire_c, set_halt_c, illegal_c;
    logic            alusrcb_c;
    logic [2:0]      aluop_c;
    logic [1:0]      extsel_c, pcsrc_c, regout_c;

    // Opcode classes used by both the sequencing and the select decode.
    always_comb begin
        is_jump  = (op_q == OP_J) || (op_q == OP_JR) || (op_q == OP_JAL);
        is_rtype = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_OR) ||
                   (op_q == OP_AND) || (op_q == OP_SLL) || (op_q == OP_MOVE) ||
                   (op_q == OP_SLT);
        is_alu   = is_rtype || (op_q == OP_ADDI) || (op_q == OP_ORI);
    end

    // State, opcode latch, sticky halt and retired counter.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IF;
            op_q    <= '0;
            halted  <= 1'b0;
            retired <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IF && imem_ready && !halted)
                op_q <= Opcode;
            if (set_halt_c)
                halted <= 1'b1;
            if (retire_c)
                retired <= retired + CNT_W'(1);
        end
    end

    // Next-state and write enables. The last cycle of every instruction
    // asserts retire_c, which doubles as the PC write enable.
    always_comb begin
        state_d     = state_q;
        irwre_c     = 1'b0;
        regwre_c    = 1'b0;
        dmemrw_c    = 1'b0;
        alum2reg_c  = 1'b0;
        wrregdata_c = 1'b0;
        retire_c    = 1'b0;
        set_halt_c  = 1'b0;
        illegal_c   = 1'b0;
        case (state_q)
            S_IF: begin
                irwre_c = imem_ready & ~halted;
                if (imem_ready && !halted)
                    state_d = S_ID;
            end
            S_ID: begin
                if (is_jump) begin
                    retire_c = 1'b1;
                    regwre_c = (op_q == OP_JAL);
                    state_d  = S_IF;
                end else if (op_q == OP_BEQ) begin
                    state_d = S_EXE3;
                end else if (op_q == OP_SW || op_q == OP_LW) begin
                    state_d = S_EXE5;
                end else if (op_q == OP_HALT) begin
                    set_halt_c = 1'b1;
                    state_d    = S_ID;
                end else if (is_alu) begin
                    state_d = S_EXE4;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_EXE3: begin
                retire_c = 1'b1;
                state_d  = S_IF;
            end
            S_EXE4: state_d = S_WB4;
            S_WB4: begin
                regwre_c    = 1'b1;
                wrregdata_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_IF;
            end
            S_EXE5: state_d = S_MEM;
            S_MEM: begin
                dmemrw_c = (op_q == OP_SW);
                if (dmem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB5;
                    end else begin
                        retire_c = (op_q == OP_SW);
                        state_d  = S_IF;
                    end
                end
            end
            S_WB5: begin
                alum2reg_c  = 1'b1;
                regwre_c    = 1'b1;
                wrregdata_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Datapath selects depend only on the latched opcode (and Zero for PCSrc).
    always_comb begin
        alusrcb_c = (op_q == OP_ADDI) || (op_q == OP_ORI) || (op_q == OP_LW) ||
                    (op_q == OP_SW) || (op_q == OP_SLL);
        aluop_c = 3'b000;
        if (op_q == OP_SUB || op_q == OP_BEQ)     aluop_c = 3'b001;
        else if (op_q == OP_OR || op_q == OP_ORI) aluop_c = 3'b101;
        else if (op_q == OP_AND)                  aluop_c = 3'b110;
        else if (op_q == OP_SLL)                  aluop_c = 3'b100;
        else if (op_q == OP_SLT)                  aluop_c = 3'b010;
        pcsrc_c = 2'b00;
        if (op_q == OP_BEQ && Zero)                pcsrc_c = 2'b01;
        else if (op_q == OP_JR)                    pcsrc_c = 2'b10;
        else if (op_q == OP_J || op_q == OP_JAL)   pcsrc_c = 2'b11;
        regout_c = 2'b11;
        if (op_q == OP_JAL)                        regout_c = 2'b00;
        else if (op_q == OP_ADDI || op_q == OP_ORI || op_q == OP_LW)
                                                   regout_c = 2'b01;
        else if (is_rtype)                         regout_c = 2'b10;
        extsel_c = 2'b11;
        if (op_q == OP_SLL)                        extsel_c = 2'b00;
        else if (op_q == OP_ORI)                   extsel_c = 2'b01;
        else if (op_q == OP_ADDI || op_q == OP_LW || op_q == OP_SW || op_q == OP_BEQ)
                                                   extsel_c = 2'b10;
    end

    // Every combinational output is forced low while Reset is held, so an
    // abort mid-instruction never leaves a write enable asserted.
    assign state     = state_q;
    assign IRWre     = Reset & irwre_c;
    assign PCWre     = Reset & retire_c;
    assign RegWre    = Reset & regwre_c;
    assign DataMemRW = Reset & dmemrw_c;
    assign ALUM2Reg  = Reset & alum2reg_c;
    assign WrRegData = Reset & wrregdata_c;
    assign ALUSrcB   = Reset & alusrcb_c;
    assign ALUOp     = Reset ? aluop_c  : 3'b000;
    assign ExtSel    = Reset ? extsel_c : 2'b00;
    assign PCSrc     = Reset ? pcsrc_c  : 2'b00;
    assign RegOut    = Reset ? regout_c : 2'b00;
    assign illegal   = Reset & illegal_c;

endmodule

// File: tb/tb_mc_control_unit.sv
// -----------------------------------------------------------------------------
// tb_mc_control_unit
// Scoreboard bench for mc_control_unit. A driver issues whole instructions
// (random opcodes, random fetch and memory stalls) and, cycle by cycle, pushes
// the behaviour expected from the instruction-level reference model into a
// queue. A monitor on the falling edge pops and compares. A second instance
// with a 2-bit counter checks counter wrap-around on the same stimulus.
// -----------------------------------------------------------------------------
module tb_mc_control_unit;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010,
                           OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010,
                           OP_SLL  = 6'b011000, OP_MOVE = 6'b100000, OP_SLT  = 6'b100111,
                           OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100,
                           OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010,
                           OP_HALT = 6'b111111;
    localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE3 = 3'b101, ST_EXE4 = 3'b110,
                           ST_EXE5 = 3'b010, ST_MEM = 3'b011, ST_WB4 = 3'b111, ST_WB5 = 3'b100;
    // Enable vector bit order: {IRWre, PCWre, RegWre, DataMemRW, ALUM2Reg, WrRegData}
    localparam logic [5:0] EN_IR = 6'b100000, EN_PC = 6'b010000, EN_RW = 6'b001000,
                           EN_DM = 6'b000100, EN_M2R = 6'b000010, EN_WRD = 6'b000001;

    typedef struct packed {
        logic [2:0]  st;
        logic [5:0]  en;
        logic [9:0]  sel;
        logic [1:0]  fl;
        logic [31:0] ret;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset, Zero, imem_ready, dmem_ready;
    logic [5:0]  Opcode;
    logic [2:0]  state, state2;
    logic        IRWre, PCWre, RegWre, ALUSrcB, ALUM2Reg, DataMemRW, WrRegData, halted, illegal;
    logic        IRWre2, PCWre2, RegWre2, ALUSrcB2, ALUM2Reg2, DataMemRW2, WrRegData2, halted2, illegal2;
    logic [2:0]  ALUOp, ALUOp2;
    logic [1:0]  ExtSel, PCSrc, RegOut, ExtSel2, PCSrc2, RegOut2;
    logic [31:0] retired;
    logic [1:0]  retired2;

    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [5:0]  prev_op = 6'b000000;
    logic [31:0] ret_cnt = 0;
    logic        halted_m = 1'b0;
    logic [5:0]  legal_ops[15] = '{OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL,
                                   OP_MOVE, OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL};

    always #5 CLK = ~CLK;

    mc_control_unit #(.OP_W(6), .CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .state(state),
        .IRWre(IRWre), .PCWre(PCWre), .RegWre(RegWre), .ALUSrcB(ALUSrcB),
        .ALUM2Reg(ALUM2Reg), .DataMemRW(DataMemRW), .WrRegData(WrRegData),
        .ALUOp(ALUOp), .ExtSel(ExtSel), .PCSrc(PCSrc), .RegOut(RegOut),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    mc_control_unit #(.OP_W(6), .CNT_W(2)) dut_w2 (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .state(state2),
        .IRWre(IRWre2), .PCWre(PCWre2), .RegWre(RegWre2), .ALUSrcB(ALUSrcB2),
        .ALUM2Reg(ALUM2Reg2), .DataMemRW(DataMemRW2), .WrRegData(WrRegData2),
        .ALUOp(ALUOp2), .ExtSel(ExtSel2), .PCSrc(PCSrc2), .RegOut(RegOut2),
        .halted(halted2), .illegal(illegal2), .retired(retired2)
    );

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_MOVE,
                           OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT});
    endfunction

    // Select outputs straight from the opcode tables: {ALUSrcB, ALUOp, ExtSel, PCSrc, RegOut}
    function automatic logic [9:0] sel_of(input logic [5:0] op, input logic z);
        logic       srcb;
        logic [2:0] aop;
        logic [1:0] ext, pcs, rout;
        srcb = op inside {OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_SLL};
        aop  = (op inside {OP_SUB, OP_BEQ}) ? 3'b001 :
               (op inside {OP_OR, OP_ORI})  ? 3'b101 :
               (op == OP_AND) ? 3'b110 : (op == OP_SLL) ? 3'b100 :
               (op == OP_SLT) ? 3'b010 : 3'b000;
        pcs  = (op == OP_BEQ && z) ? 2'b01 : (op == OP_JR) ? 2'b10 :
               (op inside {OP_J, OP_JAL}) ? 2'b11 : 2'b00;
        rout = (op == OP_JAL) ? 2'b00 :
               (op inside {OP_ADDI, OP_ORI, OP_LW}) ? 2'b01 :
               (op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_MOVE, OP_SLT}) ? 2'b10 : 2'b11;
        ext  = (op == OP_SLL) ? 2'b00 : (op == OP_ORI) ? 2'b01 :
               (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ}) ? 2'b10 : 2'b11;
        return {srcb, aop, ext, pcs, rout};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one clock cycle of inputs and queue what the DUT must show in it.
    task automatic apply_stimulus(input logic [2:0] st, input logic imem, input logic dmem,
                                  input logic [5:0] opin, input logic [5:0] en,
                                  input logic ill, input logic ret_now);
        exp_t e;
        logic z;
        @(posedge CLK);
        #1;
        z          = rb();
        Opcode     = opin;
        imem_ready = imem;
        dmem_ready = dmem;
        Zero       = z;
        e.st  = st;
        e.en  = en;
        e.sel = sel_of(prev_op, z);
        e.fl  = {halted_m, ill};
        e.ret = ret_cnt;
        exp_q.push_back(e);
        if (ret_now)
            ret_cnt = ret_cnt + 1;
    endtask

    // Instruction-level reference: the cycle path each opcode class takes.
    task automatic run_instr(input logic [5:0] op, input int istall, input int dstall);
        for (int i = 0; i < istall; i++)
            apply_stimulus(ST_IF, 1'b0, rb(), r6(), 6'b0, 1'b0, 1'b0);
        apply_stimulus(ST_IF, 1'b1, rb(), op, EN_IR, 1'b0, 1'b0);
        prev_op = op;
        if (op inside {OP_J, OP_JR, OP_JAL}) begin
            apply_stimulus(ST_ID, rb(), rb(), r6(), EN_PC | ((op == OP_JAL) ? EN_RW : 6'b0), 1'b0, 1'b1);
        end else if (op == OP_BEQ) begin
            apply_stimulus(ST_ID,   rb(), rb(), r6(), 6'b0,  1'b0, 1'b0);
            apply_stimulus(ST_EXE3, rb(), rb(), r6(), EN_PC, 1'b0, 1'b1);
        end else if (op == OP_SW || op == OP_LW) begin
            apply_stimulus(ST_ID,   rb(), rb(), r6(), 6'b0, 1'b0, 1'b0);
            apply_stimulus(ST_EXE5, rb(), rb(), r6(), 6'b0, 1'b0, 1'b0);
            for (int i = 0; i < dstall; i++)
                apply_stimulus(ST_MEM, rb(), 1'b0, r6(), (op == OP_SW) ? EN_DM : 6'b0, 1'b0, 1'b0);
            apply_stimulus(ST_MEM, rb(), 1'b1, r6(), (op == OP_SW) ? (EN_DM | EN_PC) : 6'b0,
                           1'b0, op == OP_SW);
            if (op == OP_LW)
                apply_stimulus(ST_WB5, rb(), rb(), r6(), EN_M2R | EN_RW | EN_WRD | EN_PC, 1'b0, 1'b1);
        end else if (op == OP_HALT) begin
            apply_stimulus(ST_ID, rb(), rb(), r6(), 6'b0, 1'b0, 1'b0);
            halted_m = 1'b1;
            repeat (8) apply_stimulus(ST_ID, rb(), rb(), r6(), 6'b0, 1'b0, 1'b0);
        end else if (is_legal(op)) begin
            apply_stimulus(ST_ID,   rb(), rb(), r6(), 6'b0, 1'b0, 1'b0);
            apply_stimulus(ST_EXE4, rb(), rb(), r6(), 6'b0, 1'b0, 1'b0);
            apply_stimulus(ST_WB4,  rb(), rb(), r6(), EN_RW | EN_WRD | EN_PC, 1'b0, 1'b1);
        end else begin
            apply_stimulus(ST_ID, rb(), rb(), r6(), 6'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, "_outs"}, 64'({state, IRWre, PCWre, RegWre, ALUSrcB, ALUM2Reg,
                     DataMemRW, WrRegData, ALUOp, ExtSel, PCSrc, RegOut, halted, illegal}), 64'd0);
        check_output({name, "_retired"}, 64'(retired), 64'd0);
        check_output({name, "_w2"}, 64'({state2, IRWre2, PCWre2, RegWre2, ALUSrcB2, ALUM2Reg2,
                     DataMemRW2, WrRegData2, ALUOp2, ExtSel2, PCSrc2, RegOut2, halted2,
                     illegal2, retired2}), 64'd0);
    endtask

    // Assert reset mid-cycle (after the last queued cycle was checked), check
    // the asynchronous clear, then release with fetch idle.
    task automatic do_reset(input string name);
        @(negedge CLK);
        #2;
        mon_en     = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        Reset      = 1'b0;
        #1;
        check_all_zero(name);
        @(posedge CLK);
        #1;
        imem_ready = 1'b0;
        Reset      = 1'b1;
        ret_cnt    = 0;
        prev_op    = 6'b000000;
        halted_m   = 1'b0;
        mon_en     = 1'b1;
    endtask

    // Monitor: compare every queued cycle on the falling edge.
    always @(negedge CLK) begin
        if (mon_en && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_output("state", 64'(state), 64'(mon_e.st));
            check_output("enables", 64'({IRWre, PCWre, RegWre, DataMemRW, ALUM2Reg, WrRegData}),
                         64'(mon_e.en));
            check_output("selects", 64'({ALUSrcB, ALUOp, ExtSel, PCSrc, RegOut}), 64'(mon_e.sel));
            check_output("halted_illegal", 64'({halted, illegal}), 64'(mon_e.fl));
            check_output("retired", 64'(retired), 64'(mon_e.ret));
            check_output("w2_ctrl", 64'({state2, IRWre2, PCWre2, RegWre2, DataMemRW2, ALUM2Reg2,
                         WrRegData2, ALUSrcB2, ALUOp2, ExtSel2, PCSrc2, RegOut2, halted2, illegal2}),
                         64'({mon_e.st, mon_e.en, mon_e.sel, mon_e.fl}));
            check_output("w2_retired", 64'(retired2), 64'(mon_e.ret[1:0]));
        end
    end

    initial begin
        logic [5:0] op;
        Reset      = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        Zero       = 1'b1;
        Opcode     = OP_LW;
        #2;
        check_all_zero("reset_init");
        @(posedge CLK);
        #1;
        check_all_zero("reset_held");
        imem_ready = 1'b0;
        Reset      = 1'b1;
        mon_en     = 1'b1;

        // Directed sequence covering each instruction class and stalls.
        run_instr(OP_ADD, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_BEQ, 1, 0);
        run_instr(OP_JAL, 0, 0);
        run_instr(6'b101010, 0, 0);
        run_instr(OP_SW, 2, 2);
        run_instr(OP_JR, 0, 0);
        run_instr(OP_J, 0, 0);

        // Random instruction stream with occasional unknown opcodes.
        repeat (120) begin
            if ($urandom_range(0, 7) == 0) begin
                op = r6();
                while (is_legal(op))
                    op = r6();
            end else begin
                op = legal_ops[$urandom_range(0, 14)];
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        // Abort a store while it waits in MEM.
        apply_stimulus(ST_IF, 1'b1, 1'b0, OP_SW, EN_IR, 1'b0, 1'b0);
        prev_op = OP_SW;
        apply_stimulus(ST_ID,   1'b0, 1'b0, r6(), 6'b0,  1'b0, 1'b0);
        apply_stimulus(ST_EXE5, 1'b0, 1'b0, r6(), 6'b0,  1'b0, 1'b0);
        apply_stimulus(ST_MEM,  1'b0, 1'b0, r6(), EN_DM, 1'b0, 1'b0);
        apply_stimulus(ST_MEM,  1'b0, 1'b0, r6(), EN_DM, 1'b0, 1'b0);
        do_reset("reset_mid_mem");

        // Four jumps wrap the 2-bit counter back to zero.
        repeat (4) run_instr(OP_J, 0, 0);
        run_instr(OP_ADD, 1, 0);

        // Halt sticks in ID until reset.
        run_instr(OP_HALT, 0, 0);
        do_reset("reset_after_halt");
        run_instr(OP_ORI, 0, 0);
        run_instr(OP_SLT, 0, 0);

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
